// File: rtl/banco_reg_pkg.sv
// ----------------------------------------------------------------------------
// banco_reg_pkg
// Shared constants and types for the banco_reg register file.
//   DEFAULT_DATA_W : default register / data-port width (32)
//   DEFAULT_ADDR_W : default register index width (2)
//   NREGS          : register count for the default geometry (2**ADDR_W)
//   reg_idx_t      : register index type (default geometry)
//   reg_data_t     : register data type (default geometry)
// ----------------------------------------------------------------------------
package banco_reg_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 2;
    localparam int NREGS          = 2 ** DEFAULT_ADDR_W;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage : banco_reg_pkg

// File: rtl/banco_reg_rd_port.sv
// ----------------------------------------------------------------------------
// banco_reg_rd_port
// One combinational read port of the register file: selects one register
// from the flattened storage array.  When BANCO_REG_BYPASS_EN is defined, a
// write aimed at the same index in the current cycle is forwarded straight
// from the write data, so the reader sees the new value before the edge.
//
// Ports:
//   rst      in  : reset; suppresses forwarding while asserted
//   wr_en    in  : write enable of the write port
//   wr_idx   in  : index being written
//   wr_data  in  : data being written
//   rd_idx   in  : index to read
//   regs     in  : all register contents, packed
//   rd_data  out : selected register (or forwarded write data)
//
// Configuration macro: BANCO_REG_BYPASS_EN (write-through forwarding).
// ----------------------------------------------------------------------------
module banco_reg_rd_port
    import banco_reg_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [ADDR_W-1:0]                   wr_idx,
    input  logic [DATA_W-1:0]                   wr_data,
    input  logic [ADDR_W-1:0]                   rd_idx,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]  regs,
    output logic [DATA_W-1:0]                   rd_data
);

`ifdef BANCO_REG_BYPASS_EN
    always_comb begin
        rd_data = regs[rd_idx];
        // Forward the in-flight write so the read does not lag by a cycle.
        if (!rst && wr_en && (rd_idx == wr_idx)) begin
            rd_data = wr_data;
        end
    end
`else
    // Forwarding inputs are only consumed in the bypass build.
    logic unused_fwd;
    assign unused_fwd = ^{rst, wr_en, wr_idx, wr_data};

    always_comb begin
        rd_data = regs[rd_idx];
    end
`endif

endmodule : banco_reg_rd_port

// File: rtl/banco_reg.sv
// ----------------------------------------------------------------------------
// banco_reg
// General-purpose register file for the MIPS-calculator datapath:
// 2**ADDR_W registers of DATA_W bits, one synchronous write port and two
// combinational read ports.  Feeds both ALU operands and takes write-back.
//
// Ports:
//   clk        in  : clock, state changes on rising edge
//   rst        in  : asynchronous active-high reset, clears all registers
//   IdReg      in  : write index
//   Fonte1     in  : read index, port 1
//   Fonte2     in  : read index, port 2
//   Escrita    in  : write enable
//   Dado       in  : write data
//   DadoLido1  out : reg[Fonte1]
//   DadoLido2  out : reg[Fonte2]
//
// Configuration macro: BANCO_REG_BYPASS_EN enables write-through forwarding
// on both read ports; without it reads always return stored contents.
// ----------------------------------------------------------------------------
module banco_reg
    import banco_reg_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] IdReg,
    input  logic [ADDR_W-1:0] Fonte1,
    input  logic [ADDR_W-1:0] Fonte2,
    input  logic              Escrita,
    input  logic [DATA_W-1:0] Dado,
    output logic [DATA_W-1:0] DadoLido1,
    output logic [DATA_W-1:0] DadoLido2
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    // Storage: cleared asynchronously; the write index is only looked at
    // when Escrita is high, so an undriven IdReg cannot disturb state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (Escrita) begin
            regs[IdReg] <= Dado;
        end
    end

    banco_reg_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port1 (
        .rst     (rst),
        .wr_en   (Escrita),
        .wr_idx  (IdReg),
        .wr_data (Dado),
        .rd_idx  (Fonte1),
        .regs    (regs),
        .rd_data (DadoLido1)
    );

    banco_reg_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port2 (
        .rst     (rst),
        .wr_en   (Escrita),
        .wr_idx  (IdReg),
        .wr_data (Dado),
        .rd_idx  (Fonte2),
        .regs    (regs),
        .rd_data (DadoLido2)
    );

endmodule : banco_reg

// File: tb/tb_banco_reg.sv
// ----------------------------------------------------------------------------
// tb_banco_reg
// Scoreboard bench for banco_reg.  The stimulus process drives the inputs,
// pushes the hand-computed expected read values into a queue and signals the
// monitor, which samples both read ports and compares.
// ----------------------------------------------------------------------------
module tb_banco_reg;
    import banco_reg_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    reg_idx_t  IdReg;
    reg_idx_t  Fonte1;
    reg_idx_t  Fonte2;
    logic      Escrita;
    reg_data_t Dado;
    reg_data_t DadoLido1;
    reg_data_t DadoLido2;

    banco_reg dut (
        .clk       (clk),
        .rst       (rst),
        .IdReg     (IdReg),
        .Fonte1    (Fonte1),
        .Fonte2    (Fonte2),
        .Escrita   (Escrita),
        .Dado      (Dado),
        .DadoLido1 (DadoLido1),
        .DadoLido2 (DadoLido2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string     name;
        reg_data_t e1;
        reg_data_t e2;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   n_cmp = 0;
    int   n_bad = 0;

    reg_data_t model[NREGS];

`ifdef BANCO_REG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Monitor: drains the scoreboard whenever stimulus presents a sample.
    initial begin
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                n_cmp++;
                if (DadoLido1 !== e.e1) begin
                    n_bad++;
                    $display("FAIL %s port1: got %h expected %h", e.name, DadoLido1, e.e1);
                end
                n_cmp++;
                if (DadoLido2 !== e.e2) begin
                    n_bad++;
                    $display("FAIL %s port2: got %h expected %h", e.name, DadoLido2, e.e2);
                end
            end
        end
    end

    task automatic check(input string name, input reg_idx_t f1, input reg_idx_t f2,
                         input reg_data_t e1, input reg_data_t e2);
        exp_t e;
        Fonte1 = f1;
        Fonte2 = f2;
        #1;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        q.push_back(e);
        ->chk_ev;
        for (int t = 0; t < 20 && q.size() > 0; t++) #0.1;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL %s monitor: got pending=%0d expected pending=0", name, q.size());
            q.delete();
        end
    endtask

    task automatic write_reg(input reg_idx_t idx, input reg_data_t d);
        @(negedge clk);
        IdReg   = idx;
        Dado    = d;
        Escrita = 1'b1;
        @(posedge clk);
        model[idx] = d;
        @(negedge clk);
        Escrita = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        Escrita = 1'b1;
        IdReg   = '0;
        Dado    = 32'h0000_07E3;
        Fonte1  = '0;
        Fonte2  = '0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;

        // Reset held across two edges with a write pending: nothing stored.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NREGS; i++) begin
            check("reset_hold", reg_idx_t'(i), reg_idx_t'(NREGS-1-i), 32'h0, 32'h0);
        end

        // Release reset with the write still presented: reg0 takes it.
        rst = 1'b0;
        @(posedge clk);
        model[0] = 32'h0000_07E3;
        @(negedge clk);
        Escrita = 1'b0;
        check("basic_rd", 2'd0, 2'd1, 32'h0000_07E3, 32'h0);

        // Fill all registers and sweep every read-index pair.
        write_reg(2'd0, 32'h1111_1111);
        write_reg(2'd1, 32'h2222_2222);
        write_reg(2'd2, 32'h3333_3333);
        write_reg(2'd3, 32'hFFFF_FFFF);
        begin
            reg_data_t vals[NREGS];
            vals[0] = 32'h1111_1111;
            vals[1] = 32'h2222_2222;
            vals[2] = 32'h3333_3333;
            vals[3] = 32'hFFFF_FFFF;
            for (int a = 0; a < NREGS; a++) begin
                for (int b = 0; b < NREGS; b++) begin
                    check("sweep", reg_idx_t'(a), reg_idx_t'(b), vals[a], vals[b]);
                end
            end
        end

        // Write disabled for three edges: reg2 untouched.
        @(negedge clk);
        Escrita = 1'b0;
        IdReg   = 2'd2;
        Dado    = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("wr_disable", 2'd2, 2'd2, 32'h3333_3333, 32'h3333_3333);

        // Read-during-write on port 1, port 2 on an unrelated register.
        IdReg   = 2'd1;
        Dado    = 32'hA5A5_A5A5;
        Escrita = 1'b1;
        check("rdw_before", 2'd1, 2'd0,
              BYPASS ? 32'hA5A5_A5A5 : 32'h2222_2222, 32'h1111_1111);
        @(posedge clk);
        @(negedge clk);
        Escrita = 1'b0;
        check("rdw_after", 2'd1, 2'd1, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

        // Full-width value survives storage intact.
        write_reg(2'd3, 32'h8000_0001);
        check("full_width", 2'd3, 2'd2, 32'h8000_0001, 32'h3333_3333);

        // Asynchronous reset between edges, with a write presented.
        @(negedge clk);
        IdReg   = 2'd3;
        Dado    = 32'h1234_5678;
        Escrita = 1'b1;
        #2;
        rst = 1'b1;
        check("async_rst", 2'd3, 2'd1, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst_wr_drop", 2'd3, 2'd0, 32'h0, 32'h0);
        Escrita = 1'b0;
        rst     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_a", 2'd3, 2'd1, 32'h0, 32'h0);
        check("post_rst_b", 2'd0, 2'd2, 32'h0, 32'h0);

        // Register file usable again after reset.
        write_reg(2'd2, 32'h0BAD_CAFE);
        check("post_rst_wr", 2'd2, 2'd3, 32'h0BAD_CAFE, 32'h0);

        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_banco_reg
